// File: rtl/rr_queue_arbiter.sv
// rr_queue_arbiter: packet-level round-robin merge of NUM_QUEUES non-fallthrough FIFOs
// into one word stream; a whole packet is forwarded per grant.
module rr_queue_arbiter #(
   parameter int WIDTH           = 73,
   parameter int NUM_QUEUES      = 4,
   parameter int NUM_QUEUES_BITS = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_QUEUES*WIDTH-1:0] fifo_dout,
   input  logic [NUM_QUEUES-1:0]       fifo_empty,
   output logic [NUM_QUEUES-1:0]       fifo_rd_en,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_wr,
   input  logic                        out_rdy,
   output logic [31:0]                 pkt_count
);
   typedef enum logic {IDLE, READ} state_t;
   state_t                          state_q, state_d;
   logic [NUM_QUEUES_BITS-1:0]      grant_q, grant_d, last_grant_q, last_grant_d, cand;
   logic                            out_wr_q, out_wr_d;
   logic [31:0]                     pkt_count_q, pkt_count_d;
   logic [NUM_QUEUES-1:0][WIDTH-1:0] dout_v;
   logic                            eop;
   assign dout_v    = fifo_dout;
   assign out_wr    = out_wr_q;
   assign pkt_count = pkt_count_q;
   assign out_data  = out_wr_q ? dout_v[grant_q] : '0;
   assign eop       = out_wr_q && out_data[WIDTH-1];
   // Holding reads while the EOP word is on the output keeps the next packet's head in its FIFO.
   always_comb begin
      fifo_rd_en = '0;
      fifo_rd_en[grant_q] = state_q == READ && !fifo_empty[grant_q] && out_rdy && !eop;
      out_wr_d = |fifo_rd_en;
      state_d = state_q;
      grant_d = grant_q;
      last_grant_d = last_grant_q;
      pkt_count_d = pkt_count_q;
      cand = '0;
      if (state_q == IDLE && !(&fifo_empty)) begin
         for (int k = NUM_QUEUES; k >= 1; k--) begin
            cand = NUM_QUEUES_BITS'((int'(last_grant_q) + k) % NUM_QUEUES);
            grant_d = fifo_empty[cand] ? grant_d : cand;
         end
         last_grant_d = grant_d;
         state_d = READ;
      end else if (state_q == READ && eop) begin
         state_d = IDLE;
         pkt_count_d = pkt_count_q + 32'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= NUM_QUEUES_BITS'(NUM_QUEUES - 1);
         out_wr_q     <= 1'b0;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         out_wr_q     <= out_wr_d;
         pkt_count_q  <= pkt_count_d;
      end
   end
endmodule

// File: tb/tb_rr_queue_arbiter.sv
// tb_rr_queue_arbiter: directed scenarios against behavioural non-fallthrough FIFOs
// (data one cycle after rd_en, empty updated on the clock edge).
module tb_rr_queue_arbiter;
   localparam int W = 73;
   localparam int N = 4;
   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N*W-1:0] fifo_dout;
   logic [N-1:0]   fifo_empty;
   logic [N-1:0]   fifo_rd_en;
   logic [W-1:0]   out_data;
   logic           out_wr;
   logic           out_rdy = 1'b1;
   logic [31:0]    pkt_count;
   int checks = 0;
   int errors = 0;
   logic [W-1:0] fq[N][$];
   logic [W-1:0] dout_r[N] = '{default: '0};
   logic [N-1:0] empty_r = '1;
   logic [W-1:0] obs[$];
   int           obs_cyc[$];
   int           rd_cyc[$];
   int           rd_cnt[N] = '{default: 0};
   int           prot_err = 0;
   int           cyc = 0;

   rr_queue_arbiter #(.WIDTH(W), .NUM_QUEUES(N), .NUM_QUEUES_BITS(2)) dut (
      .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_wr(out_wr),
      .out_rdy(out_rdy), .pkt_count(pkt_count));

   always #5 clk = ~clk;

   always_comb for (int i = 0; i < N; i++) fifo_dout[i*W +: W] = dout_r[i];
   assign fifo_empty = empty_r;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (fifo_rd_en[i] && fq[i].size() > 0) dout_r[i] <= fq[i].pop_front();
         empty_r[i] <= fq[i].size() == 0;
      end
   end

   // Protocol watch: no read of an empty queue, one-hot strobes, zero data when idle.
   always @(negedge clk) begin
      if (out_wr) begin
         obs.push_back(out_data);
         obs_cyc.push_back(cyc);
      end
      if (|fifo_rd_en) rd_cyc.push_back(cyc);
      for (int i = 0; i < N; i++) if (fifo_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      if ((fifo_rd_en & fifo_empty) != 0 || !$onehot0(fifo_rd_en) || (!out_wr && out_data != '0))
         prot_err <= prot_err + 1;
   end

   function automatic logic [W-1:0] wd(input int q, input int pkt, input int i, input bit e);
      return {e, 72'(q * 4096 + pkt * 64 + i)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      out_rdy = 1'b1;
      for (int i = 0; i < N; i++) fq[i].delete();
      tick();
      tick();
   endtask

   task automatic push(input int q, input int pkt, input int len);
      for (int i = 0; i < len; i++) fq[q].push_back(wd(q, pkt, i, i == len - 1));
   endtask

   task automatic wait_words(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget && obs.size() < n; i++) tick();
      ok = obs.size() >= n;
   endtask

   task automatic test_reset();
      hold_reset();
      checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr got %b want 0", out_wr); end
      checks++; if (fifo_rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0000", fifo_rd_en); end
      checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      reset = 1'b0;
      tick();
      tick();
      checks++; if (fifo_rd_en !== 4'b0 || out_wr !== 1'b0) begin errors++; $display("FAIL empty_idle got rd_en=%b out_wr=%b want 0000/0", fifo_rd_en, out_wr); end
   endtask

   task automatic test_single_packet();
      int base, rbase, r0, rel, p0, bad;
      bit ok;
      logic [W-1:0] exp[$];
      hold_reset();
      push(0, 0, 3);
      tick();
      base = obs.size(); rbase = rd_cyc.size(); r0 = rd_cnt[0]; rel = cyc; p0 = prot_err;
      reset = 1'b0;
      wait_words(base + 3, 20, ok);
      repeat (6) tick();
      for (int i = 0; i < 3; i++) exp.push_back(wd(0, 0, i, i == 2));
      bad = 0;
      for (int i = 0; i < 3; i++) if (obs[base+i] !== exp[i]) bad++;
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d words want 3", obs.size() - base); end
      checks++; if (bad != 0) begin errors++; $display("FAIL single_words got %0d wrong want 0", bad); end
      checks++; if (obs.size() - base != 3) begin errors++; $display("FAIL single_count got %0d want 3", obs.size() - base); end
      checks++; if (rd_cyc[rbase] != rel + 1 || rd_cyc[rbase+2] != rel + 3) begin errors++; $display("FAIL single_rd_timing got %0d..%0d want %0d..%0d", rd_cyc[rbase] - rel, rd_cyc[rbase+2] - rel, 1, 3); end
      checks++; if (rd_cnt[0] - r0 != 3) begin errors++; $display("FAIL single_rd_count got %0d want 3", rd_cnt[0] - r0); end
      checks++; if (obs_cyc[base] != rel + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_cyc[base] - rel, 2); end
      checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt_count got %0d want 1", pkt_count); end
      checks++; if (prot_err != p0) begin errors++; $display("FAIL single_protocol got %0d violations want 0", prot_err - p0); end
   endtask

   task automatic test_round_robin();
      int base, p0, bad, gap_bad, run_bad;
      bit ok;
      logic [W-1:0] exp[$];
      hold_reset();
      for (int p = 0; p < 2; p++) for (int q = 0; q < N; q++) push(q, p, 2);
      tick();
      base = obs.size(); p0 = prot_err;
      reset = 1'b0;
      wait_words(base + 16, 150, ok);
      repeat (6) tick();
      for (int p = 0; p < 2; p++) for (int q = 0; q < N; q++) begin
         exp.push_back(wd(q, p, 0, 0));
         exp.push_back(wd(q, p, 1, 1));
      end
      bad = 0; gap_bad = 0; run_bad = 0;
      for (int i = 0; i < 16; i++) if (obs[base+i] !== exp[i]) bad++;
      for (int k = 0; k < 8; k++) if (obs_cyc[base+2*k+1] - obs_cyc[base+2*k] != 1) run_bad++;
      for (int k = 1; k < 8; k++) if (obs_cyc[base+2*k] - obs_cyc[base+2*k-1] != 3) gap_bad++;
      checks++; if (!ok || obs.size() - base != 16) begin errors++; $display("FAIL rr_count got %0d want 16", obs.size() - base); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rr_order got %0d wrong want 0", bad); end
      checks++; if (run_bad != 0) begin errors++; $display("FAIL rr_contiguous got %0d split packets want 0", run_bad); end
      checks++; if (gap_bad != 0) begin errors++; $display("FAIL rr_gap got %0d wrong gaps want 0", gap_bad); end
      checks++; if (pkt_count !== 32'd8) begin errors++; $display("FAIL rr_pkt_count got %0d want 8", pkt_count); end
      checks++; if (prot_err != p0) begin errors++; $display("FAIL rr_protocol got %0d violations want 0", prot_err - p0); end
   endtask

   task automatic test_same_queue();
      int base, p0, r2, bad;
      bit ok;
      logic [W-1:0] exp[$];
      hold_reset();
      push(2, 0, 2);
      push(2, 1, 2);
      tick();
      base = obs.size(); p0 = prot_err; r2 = rd_cnt[2];
      reset = 1'b0;
      wait_words(base + 4, 40, ok);
      repeat (6) tick();
      for (int p = 0; p < 2; p++) begin
         exp.push_back(wd(2, p, 0, 0));
         exp.push_back(wd(2, p, 1, 1));
      end
      bad = 0;
      for (int i = 0; i < 4; i++) if (obs[base+i] !== exp[i]) bad++;
      checks++; if (!ok || obs.size() - base != 4) begin errors++; $display("FAIL same_count got %0d want 4", obs.size() - base); end
      checks++; if (bad != 0) begin errors++; $display("FAIL same_words got %0d wrong want 0", bad); end
      checks++; if (obs_cyc[base+2] - obs_cyc[base+1] != 3) begin errors++; $display("FAIL same_gap got %0d want 3", obs_cyc[base+2] - obs_cyc[base+1]); end
      checks++; if (rd_cnt[2] - r2 != 4) begin errors++; $display("FAIL same_rd_count got %0d want 4", rd_cnt[2] - r2); end
      checks++; if (pkt_count !== 32'd2 || prot_err != p0) begin errors++; $display("FAIL same_pkt got %0d/%0d want 2/0", pkt_count, prot_err - p0); end
   endtask

   task automatic test_stall();
      int base, p0, r1, bad, stall_bad;
      bit ok;
      logic [W-1:0] exp[$];
      hold_reset();
      push(1, 0, 6);
      tick();
      base = obs.size(); p0 = prot_err; r1 = rd_cnt[1];
      reset = 1'b0;
      for (int i = 0; i < 20 && rd_cnt[1] - r1 < 2; i++) tick();
      checks++; if (rd_cnt[1] - r1 != 2) begin errors++; $display("FAIL stall_reach got %0d reads want 2", rd_cnt[1] - r1); end
      out_rdy = 1'b0;
      #1;
      checks++; if (fifo_rd_en !== 4'b0) begin errors++; $display("FAIL stall_rd_stop got %b want 0000", fifo_rd_en); end
      checks++; if (out_wr !== 1'b1 || out_data !== wd(1, 0, 1, 0)) begin errors++; $display("FAIL stall_inflight got wr=%b data=%h want 1/%h", out_wr, out_data, wd(1, 0, 1, 0)); end
      stall_bad = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (fifo_rd_en !== 4'b0 || out_wr !== 1'b0) stall_bad++;
      end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d active cycles want 0", stall_bad); end
      tick();
      out_rdy = 1'b1;
      wait_words(base + 6, 30, ok);
      repeat (6) tick();
      for (int i = 0; i < 6; i++) exp.push_back(wd(1, 0, i, i == 5));
      bad = 0;
      for (int i = 0; i < 6; i++) if (obs[base+i] !== exp[i]) bad++;
      checks++; if (!ok || obs.size() - base != 6) begin errors++; $display("FAIL stall_count got %0d want 6", obs.size() - base); end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_words got %0d wrong want 0", bad); end
      checks++; if (rd_cnt[1] - r1 != 6 || pkt_count !== 32'd1) begin errors++; $display("FAIL stall_totals got reads=%0d pkts=%0d want 6/1", rd_cnt[1] - r1, pkt_count); end
      checks++; if (prot_err != p0) begin errors++; $display("FAIL stall_protocol got %0d violations want 0", prot_err - p0); end
   endtask

   task automatic test_empty_hold();
      int base, p0, r1, bad;
      bit ok;
      logic [W-1:0] exp[$];
      hold_reset();
      fq[0].push_back(wd(0, 0, 0, 0));
      push(1, 0, 2);
      tick();
      base = obs.size(); p0 = prot_err; r1 = rd_cnt[1];
      reset = 1'b0;
      repeat (8) tick();
      checks++; if (obs.size() - base != 1) begin errors++; $display("FAIL hold_partial got %0d words want 1", obs.size() - base); end
      checks++; if (rd_cnt[1] - r1 != 0) begin errors++; $display("FAIL hold_other got %0d reads of q1 want 0", rd_cnt[1] - r1); end
      fq[0].push_back(wd(0, 0, 1, 0));
      fq[0].push_back(wd(0, 0, 2, 1));
      wait_words(base + 5, 40, ok);
      repeat (6) tick();
      for (int i = 0; i < 3; i++) exp.push_back(wd(0, 0, i, i == 2));
      exp.push_back(wd(1, 0, 0, 0));
      exp.push_back(wd(1, 0, 1, 1));
      bad = 0;
      for (int i = 0; i < 5; i++) if (obs[base+i] !== exp[i]) bad++;
      checks++; if (!ok || obs.size() - base != 5) begin errors++; $display("FAIL hold_count got %0d want 5", obs.size() - base); end
      checks++; if (bad != 0) begin errors++; $display("FAIL hold_order got %0d wrong want 0", bad); end
      checks++; if (pkt_count !== 32'd2 || prot_err != p0) begin errors++; $display("FAIL hold_pkt got %0d/%0d want 2/0", pkt_count, prot_err - p0); end
   endtask

   task automatic test_mid_reset();
      int base, r1, bad;
      bit ok;
      hold_reset();
      fq[0].push_back(wd(0, 0, 0, 1));
      push(1, 0, 4);
      tick();
      r1 = rd_cnt[1];
      reset = 1'b0;
      for (int i = 0; i < 30 && rd_cnt[1] - r1 < 2; i++) tick();
      checks++; if (pkt_count !== 32'd1 || rd_cnt[1] - r1 != 2) begin errors++; $display("FAIL mid_setup got pkts=%0d reads=%0d want 1/2", pkt_count, rd_cnt[1] - r1); end
      reset = 1'b1;
      for (int i = 0; i < N; i++) fq[i].delete();
      fq[2].push_back(wd(2, 1, 0, 1));
      fq[0].push_back(wd(0, 1, 0, 1));
      tick();
      checks++; if (out_wr !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL mid_out got wr=%b data=%h want 0/0", out_wr, out_data); end
      checks++; if (fifo_rd_en !== 4'b0) begin errors++; $display("FAIL mid_rd_en got %b want 0000", fifo_rd_en); end
      checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mid_pkt_count got %0d want 0", pkt_count); end
      base = obs.size();
      reset = 1'b0;
      wait_words(base + 2, 30, ok);
      repeat (6) tick();
      bad = 0;
      if (obs[base] !== wd(0, 1, 0, 1)) bad++;
      if (obs[base+1] !== wd(2, 1, 0, 1)) bad++;
      checks++; if (!ok || obs.size() - base != 2) begin errors++; $display("FAIL mid_count got %0d want 2", obs.size() - base); end
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_order got %0d wrong want 0", bad); end
      checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL mid_pkt_after got %0d want 2", pkt_count); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_same_queue();
      test_stall();
      test_empty_hold();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
